capp_array: RTL

- Parametrised associative-processor array; successor to the fixed-width CAM block.
- A single valid/ready command port drives masked search, tag set/clear, select-first and masked parallel write.
- A sequenced response carries the match count, first-match index and first-match word.
- Sits between the host sequencer and the per-cell word store.

---
 rtl/capp_array.sv | 119 +++++++++++
 1 files changed

// File: rtl/capp_array.sv
// capp_array: associative-processor array with masked search, tag ops, masked parallel write and sequenced popcount response
module capp_array #(
  parameter int NUM_BITS = 32,
  parameter int NUM_CELLS = 100,
  parameter int COUNT_LANES = 8,
  localparam int IDX_W = $clog2(NUM_CELLS + 1)
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic                 cmd_valid,
  output logic                 cmd_ready,
  input  logic [2:0]           cmd_op,
  input  logic [NUM_BITS-1:0]  cmd_comparand,
  input  logic [NUM_BITS-1:0]  cmd_mask,
  output logic                 resp_valid,
  input  logic                 resp_ready,
  output logic [IDX_W-1:0]     resp_count,
  output logic [IDX_W-1:0]     resp_first,
  output logic                 resp_any,
  output logic [NUM_BITS-1:0]  resp_data,
  output logic [NUM_CELLS-1:0] tag_wires
);
  localparam int C = (NUM_CELLS + COUNT_LANES - 1) / COUNT_LANES;
  localparam int CW = $clog2(C + 1);
  localparam int PAD = (C + 1) * COUNT_LANES;
  localparam logic [IDX_W-1:0] NONE = IDX_W'(NUM_CELLS);
  typedef enum logic [1:0] {IDLE, EXEC, COUNT, RESP} state_t;
  state_t state, state_nx;
  logic [2:0] op;
  logic [NUM_BITS-1:0] comp, mask;
  logic [NUM_BITS-1:0] mem [NUM_CELLS];
  logic [NUM_CELLS-1:0] tags, match, tags_nx;
  logic [CW-1:0] chunk;
  logic [IDX_W-1:0] acc_cnt, acc_first, chunk_cnt, chunk_first;
  logic [PAD-1:0] tags_pad;
  logic [COUNT_LANES-1:0] lane;
  assign cmd_ready = state == IDLE && !RST;
  assign resp_valid = state == RESP;
  assign tag_wires = tags;
  // padding past NUM_CELLS makes the partial last chunk and the closing cycle read zeros
  assign tags_pad = PAD'(tags);
  assign lane = tags_pad[int'(chunk) * COUNT_LANES +: COUNT_LANES];
  always_ff @(posedge CLK or posedge RST)
    if (RST) state <= IDLE;
    else state <= state_nx;
  always_comb begin
    state_nx = state == IDLE  ? (cmd_valid ? EXEC : IDLE) :
               state == EXEC  ? COUNT :
               state == COUNT ? (chunk == CW'(C) ? RESP : COUNT) :
               (resp_ready ? IDLE : RESP);
  end
  always_comb begin
    match = '0;
    for (int i = 0; i < NUM_CELLS; i++) match[i] = ((mem[i] ^ comp) & mask) == '0;
  end
  always_comb begin
    tags_nx = tags;
    unique case (op)
      3'd1: tags_nx = '1;
      3'd2: tags_nx = '0;
      3'd3: tags_nx = match;
      3'd4: tags_nx = tags & match;
      3'd5: tags_nx = tags | match;
      3'd6: tags_nx = tags & (~tags + NUM_CELLS'(1));
      default: tags_nx = tags;
    endcase
  end
  always_comb begin
    chunk_cnt = '0;
    chunk_first = NONE;
    for (int j = COUNT_LANES - 1; j >= 0; j--)
      if (lane[j]) begin
        chunk_cnt = chunk_cnt + IDX_W'(1);
        chunk_first = IDX_W'(int'(chunk) * COUNT_LANES + j);
      end
  end
  // one extra COUNT cycle after the last chunk latches the totals and reads the first-match word
  always_ff @(posedge CLK or posedge RST)
    if (RST) begin
      op <= '0;
      comp <= '0;
      mask <= '0;
      tags <= '0;
      chunk <= '0;
      acc_cnt <= '0;
      acc_first <= '0;
      resp_count <= '0;
      resp_first <= '0;
      resp_any <= 1'b0;
      resp_data <= '0;
      for (int i = 0; i < NUM_CELLS; i++) mem[i] <= '0;
    end else begin
      if (cmd_valid && cmd_ready) begin
        op <= cmd_op;
        comp <= cmd_comparand;
        mask <= cmd_mask;
      end
      if (state == EXEC) begin
        tags <= tags_nx;
        chunk <= '0;
        acc_cnt <= '0;
        acc_first <= NONE;
        if (op == 3'd7)
          for (int i = 0; i < NUM_CELLS; i++)
            if (tags[i]) mem[i] <= (mem[i] & ~mask) | (comp & mask);
      end
      if (state == COUNT) begin
        chunk <= chunk + CW'(1);
        acc_cnt <= acc_cnt + chunk_cnt;
        acc_first <= acc_first == NONE ? chunk_first : acc_first;
        if (chunk == CW'(C)) begin
          resp_count <= acc_cnt;
          resp_first <= acc_first;
          resp_any <= acc_cnt != '0;
          resp_data <= acc_first < NONE ? mem[acc_first] : '0;
        end
      end
    end
endmodule
